// File: rtl/rtc_cfg_pkg.sv
// Shared types and constants for the RTC configuration writer.
// Contents:
//   state_e     - commit FSM states
//   MODE_*      - config_mode encodings
//   ADDR_*      - RTC register addresses written by each group
//   group_addr  - address of byte idx (0..2) of a configuration group
package rtc_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StASetup,
        StAStrobe,
        StAHold,
        StDSetup,
        StDStrobe,
        StDHold,
        StGap,
        StFinish
    } state_e;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_TIME   = 2'd1;
    localparam logic [1:0] MODE_DATE   = 2'd2;
    localparam logic [1:0] MODE_TIMER  = 2'd3;

    localparam logic [7:0] ADDR_SS   = 8'h21;
    localparam logic [7:0] ADDR_MM   = 8'h22;
    localparam logic [7:0] ADDR_HH   = 8'h23;
    localparam logic [7:0] ADDR_DAY  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_YEAR = 8'h26;
    localparam logic [7:0] ADDR_SS_T = 8'h41;
    localparam logic [7:0] ADDR_MM_T = 8'h42;
    localparam logic [7:0] ADDR_HH_T = 8'h43;

    function automatic logic [7:0] group_addr(input logic [1:0] mode, input logic [1:0] idx);
        logic [7:0] a;
        a = 8'h00;
        case (mode)
            MODE_TIME: begin
                case (idx)
                    2'd0:    a = ADDR_SS;
                    2'd1:    a = ADDR_MM;
                    default: a = ADDR_HH;
                endcase
            end
            MODE_DATE: begin
                case (idx)
                    2'd0:    a = ADDR_DAY;
                    2'd1:    a = ADDR_MES;
                    default: a = ADDR_YEAR;
                endcase
            end
            MODE_TIMER: begin
                case (idx)
                    2'd0:    a = ADDR_SS_T;
                    2'd1:    a = ADDR_MM_T;
                    default: a = ADDR_HH_T;
                endcase
            end
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Phase down-counter shared by every timed state of the commit FSM.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   load       - load len this cycle (state entry)
//   len        - dwell length minus one
//   expire     - high while the count is zero (last cycle of the phase)
module rtc_bus_phase_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] len,
    output logic          expire
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= len;
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/rtc_config_writer.sv
// Commits an edited configuration group (time, date or timer) to the external
// RTC over its multiplexed address/data bus when the user leaves that mode.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   config_mode         - 0 normal, 1 time, 2 date, 3 timer
//   btn_data_*          - edited BCD bytes of the three groups
//   rtc_cs_n/rd_n/wr_n  - RTC chip select / read / write strobes (active-low)
//   rtc_a_d             - 0 address phase, 1 data phase
//   rtc_bus_out/_oe     - bus drive value and tristate enable
//   busy                - commit in progress (LOAD..FINISH)
//   done                - one-cycle pulse on the FINISH cycle
module rtc_config_writer
    import rtc_cfg_pkg::*;
#(
    parameter int unsigned T_SETUP  = 3,
    parameter int unsigned T_STROBE = 10,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] config_mode,
    input  logic [7:0] btn_data_SS,
    input  logic [7:0] btn_data_MM,
    input  logic [7:0] btn_data_HH,
    input  logic [7:0] btn_data_DAY,
    input  logic [7:0] btn_data_MES,
    input  logic [7:0] btn_data_YEAR,
    input  logic [7:0] btn_data_SS_T,
    input  logic [7:0] btn_data_MM_T,
    input  logic [7:0] btn_data_HH_T,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d,
    output logic [7:0] rtc_bus_out,
    output logic       rtc_bus_oe,
    output logic       busy,
    output logic       done
);

    localparam logic [CW-1:0] SETUP_LEN  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] STROBE_LEN = CW'(T_STROBE - 1);

    state_e          state_q, state_d;
    logic [1:0]      mode_prev_q;
    logic [1:0]      group_q;
    logic            pending_q;
    logic [1:0]      pending_group_q;
    logic [1:0]      idx_q, idx_d;
    logic [2:0][7:0] data_q;
    logic [2:0][7:0] sel_bytes;
    logic            trigger;
    logic            tmr_load;
    logic            tmr_expire;
    logic [CW-1:0]   tmr_len;

    // The group being left is mode_prev, so a direct 1->2 switch commits time.
    assign trigger  = (mode_prev_q != MODE_NORMAL) && (config_mode != mode_prev_q);
    assign rtc_rd_n = 1'b1;

    always_comb begin
        sel_bytes = '0;
        case (group_q)
            MODE_TIME:  sel_bytes = {btn_data_HH, btn_data_MM, btn_data_SS};
            MODE_DATE:  sel_bytes = {btn_data_YEAR, btn_data_MES, btn_data_DAY};
            MODE_TIMER: sel_bytes = {btn_data_HH_T, btn_data_MM_T, btn_data_SS_T};
            default:    sel_bytes = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle:    if (pending_q || trigger) state_d = StLoad;
            StLoad: begin
                state_d = StASetup;
                idx_d   = 2'd0;
            end
            StASetup:  if (tmr_expire) state_d = StAStrobe;
            StAStrobe: if (tmr_expire) state_d = StAHold;
            StAHold:   if (tmr_expire) state_d = StDSetup;
            StDSetup:  if (tmr_expire) state_d = StDStrobe;
            StDStrobe: if (tmr_expire) state_d = StDHold;
            StDHold:   if (tmr_expire) state_d = StGap;
            StGap: begin
                if (tmr_expire) begin
                    if (idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StASetup;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Every state change (including GAP -> A_SETUP) restarts the phase timer.
        tmr_load = (state_d != state_q);
        tmr_len  = (state_d == StAStrobe || state_d == StDStrobe) ? STROBE_LEN : SETUP_LEN;
    end

    rtc_bus_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    // State, bookkeeping and outputs; outputs are registered from state_d so
    // they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            mode_prev_q     <= MODE_NORMAL;
            group_q         <= MODE_NORMAL;
            pending_q       <= 1'b0;
            pending_group_q <= MODE_NORMAL;
            idx_q           <= 2'd0;
            data_q          <= '0;
            rtc_cs_n        <= 1'b1;
            rtc_wr_n        <= 1'b1;
            rtc_a_d         <= 1'b0;
            rtc_bus_out     <= 8'h00;
            rtc_bus_oe      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_prev_q <= config_mode;

            if (state_q == StIdle) begin
                if (pending_q) begin
                    group_q   <= pending_group_q;
                    pending_q <= trigger;
                    if (trigger) pending_group_q <= mode_prev_q;
                end else if (trigger) begin
                    group_q <= mode_prev_q;
                end
            end else if (trigger) begin
                // Single-entry queue: a later trigger overwrites the earlier one.
                pending_q       <= 1'b1;
                pending_group_q <= mode_prev_q;
            end

            if (state_q == StLoad) data_q <= sel_bytes;

            busy       <= (state_d != StIdle);
            done       <= (state_d == StFinish);
            rtc_cs_n   <= !(state_d inside {StASetup, StAStrobe, StAHold,
                                            StDSetup, StDStrobe, StDHold});
            rtc_bus_oe <= (state_d inside {StASetup, StAStrobe, StAHold,
                                           StDSetup, StDStrobe, StDHold});
            rtc_wr_n   <= !(state_d == StAStrobe || state_d == StDStrobe);

            // Bus and a_d only change on entry to a setup phase, never under a strobe.
            if (state_d == StASetup && state_q != StASetup) begin
                rtc_a_d     <= 1'b0;
                rtc_bus_out <= group_addr(group_q, idx_d);
            end
            if (state_d == StDSetup && state_q != StDSetup) begin
                rtc_a_d     <= 1'b1;
                rtc_bus_out <= data_q[idx_q];
            end
        end
    end

endmodule

// File: tb/tb_rtc_config_writer.sv
module tb_rtc_config_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] config_mode = 2'd0;
    logic [7:0] ss = 8'h00, mm = 8'h00, hh = 8'h00;
    logic [7:0] day = 8'h00, mes = 8'h00, year = 8'h00;
    logic [7:0] ss_t = 8'h00, mm_t = 8'h00, hh_t = 8'h00;
    logic       rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_bus_oe, busy, done;
    logic [7:0] rtc_bus_out;

    int errors = 0;
    int checks = 0;

    logic        mon_en = 1'b0;
    logic        skip_width = 1'b0;
    logic [15:0] wr_log[$];

    always #5 clk = ~clk;

    rtc_config_writer dut (
        .clk           (clk),
        .reset         (reset),
        .config_mode   (config_mode),
        .btn_data_SS   (ss),
        .btn_data_MM   (mm),
        .btn_data_HH   (hh),
        .btn_data_DAY  (day),
        .btn_data_MES  (mes),
        .btn_data_YEAR (year),
        .btn_data_SS_T (ss_t),
        .btn_data_MM_T (mm_t),
        .btn_data_HH_T (hh_t),
        .rtc_cs_n      (rtc_cs_n),
        .rtc_rd_n      (rtc_rd_n),
        .rtc_wr_n      (rtc_wr_n),
        .rtc_a_d       (rtc_a_d),
        .rtc_bus_out   (rtc_bus_out),
        .rtc_bus_oe    (rtc_bus_oe),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input int i, input logic [15:0] exp);
        logic [15:0] obs;
        obs = (i < wr_log.size()) ? wr_log[i] : 16'hxxxx;
        chk($sformatf("write%0d", i), {16'h0, obs}, {16'h0, exp});
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < maxc);
        chk("done_seen", {31'h0, done}, 32'h1);
    endtask

    // Bus monitor: logs addr/data pairs and checks strobe protocol and width.
    initial begin
        logic       in_strobe;
        int         low_cnt;
        logic       cap_ad;
        logic [7:0] cap_bus, last_addr;
        in_strobe = 1'b0;
        low_cnt   = 0;
        cap_ad    = 1'b0;
        cap_bus   = 8'h00;
        last_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                assert (rtc_rd_n === 1'b1) else begin
                    errors++;
                    $error("FAIL rd_n: observed %b expected 1", rtc_rd_n);
                end
                if (rtc_wr_n === 1'b0) begin
                    if (!in_strobe) begin
                        in_strobe = 1'b1;
                        low_cnt   = 0;
                        cap_ad    = rtc_a_d;
                        cap_bus   = rtc_bus_out;
                        if (!rtc_a_d) last_addr = rtc_bus_out;
                        else wr_log.push_back({last_addr, rtc_bus_out});
                    end
                    low_cnt++;
                    checks++;
                    assert ({rtc_cs_n, rtc_bus_oe, rtc_a_d, rtc_bus_out} ===
                            {1'b0, 1'b1, cap_ad, cap_bus}) else begin
                        errors++;
                        $error("FAIL strobe_proto: observed cs/oe/ad/bus %b%b%b %h expected 01%b %h",
                               rtc_cs_n, rtc_bus_oe, rtc_a_d, rtc_bus_out, cap_ad, cap_bus);
                    end
                end else if (in_strobe) begin
                    in_strobe = 1'b0;
                    if (!skip_width) begin
                        checks++;
                        assert (low_cnt == 10) else begin
                            errors++;
                            $error("FAIL strobe_width: observed %0d expected 10", low_cnt);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int  cyc;
        logic seen;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'h0, rtc_cs_n}, 32'h1);
        chk("rst_rd_n", {31'h0, rtc_rd_n}, 32'h1);
        chk("rst_wr_n", {31'h0, rtc_wr_n}, 32'h1);
        chk("rst_a_d", {31'h0, rtc_a_d}, 32'h0);
        chk("rst_bus", {24'h0, rtc_bus_out}, 32'h0);
        chk("rst_oe", {31'h0, rtc_bus_oe}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // 0->0 activity never triggers
        repeat (5) @(negedge clk);
        chk("idle_no_trigger", {31'h0, busy}, 32'h0);

        // Time commit 1->0, exact latency
        ss = 8'h45; mm = 8'h30; hh = 8'h12;
        wr_log.delete();
        config_mode = 2'd1;
        @(negedge clk);
        config_mode = 2'd0;
        for (int c = 1; c <= 107; c++) begin
            @(negedge clk);
            if (c == 1)   chk("time_load_busy", {31'h0, busy}, 32'h1);
            if (c == 106) chk("time_done_early", {31'h0, done}, 32'h0);
            if (c == 107) chk("time_done", {30'h0, done, busy}, 32'h3);
        end
        @(negedge clk);
        chk("time_busy_fall", {30'h0, done, busy}, 32'h0);
        chk("time_nwrites", wr_log.size(), 32'd3);
        chk_log(0, 16'h2145);
        chk_log(1, 16'h2230);
        chk_log(2, 16'h2312);

        // Direct switch 2->3 commits date only
        day = 8'h07; mes = 8'h04; year = 8'h16;
        ss_t = 8'h11; mm_t = 8'h22; hh_t = 8'h33;
        wr_log.delete();
        config_mode = 2'd2;
        @(negedge clk);
        config_mode = 2'd3;
        wait_done(120, cyc);
        chk("date_latency", cyc, 32'd107);
        repeat (10) @(negedge clk);
        chk("date_no_timer", {31'h0, busy}, 32'h0);
        chk("date_nwrites", wr_log.size(), 32'd3);
        chk_log(0, 16'h2407);
        chk_log(1, 16'h2504);
        chk_log(2, 16'h2616);
        config_mode = 2'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Snapshot stability, plus a trigger landing on the FINISH cycle
        ss = 8'h45; mm = 8'h30; hh = 8'h12;
        wr_log.delete();
        config_mode = 2'd1;
        @(negedge clk);
        config_mode = 2'd0;
        for (int c = 1; c <= 107; c++) begin
            @(negedge clk);
            if (c == 3)   ss = 8'h59;
            if (c == 106) config_mode = 2'd2;
            if (c == 107) begin
                chk("snap_done", {31'h0, done}, 32'h1);
                config_mode = 2'd0;
            end
        end
        @(negedge clk);
        chk("fin_q_idle", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("fin_q_load", {31'h0, busy}, 32'h1);
        wait_done(120, cyc);
        chk("fin_q_nwrites", wr_log.size(), 32'd6);
        chk_log(0, 16'h2145);
        chk_log(3, 16'h2407);
        chk_log(5, 16'h2616);

        // Two triggers during a commit: only the last (timer) is queued
        repeat (3) @(negedge clk);
        ss = 8'h45;
        wr_log.delete();
        config_mode = 2'd1;
        @(negedge clk);
        config_mode = 2'd0;
        for (int c = 1; c <= 107; c++) begin
            @(negedge clk);
            if (c == 10) config_mode = 2'd2;
            if (c == 11) config_mode = 2'd0;
            if (c == 20) config_mode = 2'd3;
            if (c == 21) config_mode = 2'd0;
            if (c == 107) chk("q_first_done", {31'h0, done}, 32'h1);
        end
        @(negedge clk);
        chk("q_gap_idle", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("q_second_load", {31'h0, busy}, 32'h1);
        wait_done(120, cyc);
        chk("q_second_latency", cyc, 32'd106);
        repeat (10) @(negedge clk);
        chk("q_no_third", {31'h0, busy}, 32'h0);
        chk("q_nwrites", wr_log.size(), 32'd6);
        chk_log(2, 16'h2312);
        chk_log(3, 16'h4111);
        chk_log(4, 16'h4222);
        chk_log(5, 16'h4333);

        // Reset during the data strobe of 0x22, with a timer commit queued
        config_mode = 2'd1;
        @(negedge clk);
        config_mode = 2'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) config_mode = 2'd3;
            if (c == 6) config_mode = 2'd0;
        end
        chk("rst_mid_strobe", {22'h0, rtc_wr_n, rtc_a_d, rtc_bus_out}, {22'h0, 1'b0, 1'b1, 8'h30});
        skip_width = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_outs", {28'h0, rtc_wr_n, rtc_cs_n, rtc_bus_oe, busy}, {28'h0, 4'b1100});
        seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("rst_no_done_no_pending", {31'h0, seen}, 32'h0);
        skip_width = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
